// File: rtl/pipe_branch_hazard_ctrl.sv
// Hazard and branch scheduler beside the decode stage: load-use bubble, operand
// forwarding select, 2-bit branch history table, mispredict flush and statistics.
module pipe_branch_hazard_ctrl #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic [31:0]      id_pc,
  input  logic             id_pred,
  input  logic             id_taken,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             id_rs1_isreg,
  input  logic             id_rs2_isreg,
  input  logic             exe_wreg,
  input  logic             exe_m2reg,
  input  logic [4:0]       exe_rn,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [4:0]       mem_rn,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_W;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  state_t state_reg;

  logic hit_exe_a, hit_exe_b, hit_mem_a, hit_mem_b;
  logic raw_ld;
  logic resolve;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] id_idx;
  logic [1:0]       bht_reg [ENTRIES];

  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [2];

  // Register 0 is hardwired, so a write to it never produces a dependency.
  assign hit_exe_a = exe_wreg & (exe_rn != 5'd0) & id_rs1_isreg & (exe_rn == rs);
  assign hit_exe_b = exe_wreg & (exe_rn != 5'd0) & id_rs2_isreg & (exe_rn == rt);
  assign hit_mem_a = mem_wreg & (mem_rn != 5'd0) & id_rs1_isreg & (mem_rn == rs);
  assign hit_mem_b = mem_wreg & (mem_rn != 5'd0) & id_rs2_isreg & (mem_rn == rt);

  // An EXE load hit selects the regfile; the bubble makes it a MEM load hit next cycle.
  always_comb begin
    fwda = 2'b00;
    if (hit_exe_a && !exe_m2reg) begin
      fwda = 2'b01;
    end else if (hit_mem_a) begin
      fwda = mem_m2reg ? 2'b11 : 2'b10;
    end
  end

  always_comb begin
    fwdb = 2'b00;
    if (hit_exe_b && !exe_m2reg) begin
      fwdb = 2'b01;
    end else if (hit_mem_b) begin
      fwdb = mem_m2reg ? 2'b11 : 2'b10;
    end
  end

  assign raw_ld = id_valid & exe_wreg & exe_m2reg & (hit_exe_a | hit_exe_b);

  always_ff @(posedge clk) begin
    if (clrn) begin
      state_reg <= RUN;
    end else begin
      case (state_reg)
        RUN:     state_reg <= raw_ld ? BUBBLE : RUN;
        BUBBLE:  state_reg <= RUN;
        default: state_reg <= RUN;
      endcase
    end
  end

  // The BUBBLE state caps a stuck load-use condition at one stall cycle.
  assign stall   = (state_reg == RUN) & raw_ld;
  assign resolve = id_valid & id_is_branch & ~stall;
  assign flush   = resolve & (id_taken != id_pred);

  assign if_idx     = if_pc[IDX_W+1:2];
  assign id_idx     = id_pc[IDX_W+1:2];
  assign pred_taken = bht_reg[if_idx][1];

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_bht
      always_ff @(posedge clk) begin
        if (clrn) begin
          bht_reg[gi] <= 2'b01;
        end else if (resolve && (id_idx == IDX_W'(gi))) begin
          if (id_taken && (bht_reg[gi] != 2'b11)) begin
            bht_reg[gi] <= bht_reg[gi] + 2'd1;
          end else if (!id_taken && (bht_reg[gi] != 2'b00)) begin
            bht_reg[gi] <= bht_reg[gi] - 2'd1;
          end
        end
      end
    end
  endgenerate

  assign cnt_inc = {flush, stall};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (clrn) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign stall_cnt   = cnt_reg[0];
  assign mispred_cnt = cnt_reg[1];

  // Byte offset and high PC bits do not take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], id_pc[31:IDX_W+2], id_pc[1:0]};

endmodule

// File: tb/tb_pipe_branch_hazard_ctrl.sv
// Directed bench for pipe_branch_hazard_ctrl with a cycle-level reference model
// checked on every falling edge plus hand-computed literal expectations.
module tb_pipe_branch_hazard_ctrl;

  localparam int IDX_W = 6;
  localparam int CNT_W = 4;
  localparam int NENT  = 1 << IDX_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             clrn = 1'b1;
  logic [31:0]      if_pc = '0;
  logic             pred_taken;
  logic             id_valid = 0, id_is_branch = 0, id_pred = 0, id_taken = 0;
  logic [31:0]      id_pc = '0;
  logic [4:0]       rs = '0, rt = '0;
  logic             id_rs1_isreg = 0, id_rs2_isreg = 0;
  logic             exe_wreg = 0, exe_m2reg = 0, mem_wreg = 0, mem_m2reg = 0;
  logic [4:0]       exe_rn = '0, mem_rn = '0;
  logic             stall, flush;
  logic [1:0]       fwda, fwdb;
  logic [CNT_W-1:0] stall_cnt, mispred_cnt;

  pipe_branch_hazard_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn), .if_pc(if_pc), .pred_taken(pred_taken),
    .id_valid(id_valid), .id_is_branch(id_is_branch), .id_pc(id_pc),
    .id_pred(id_pred), .id_taken(id_taken), .rs(rs), .rt(rt),
    .id_rs1_isreg(id_rs1_isreg), .id_rs2_isreg(id_rs2_isreg),
    .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_rn(exe_rn),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
    .stall(stall), .flush(flush), .fwda(fwda), .fwdb(fwdb),
    .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: counter values per table slot, last-cycle stall flag, totals.
  int m_bht [NENT];
  bit m_stalled_last = 0;
  int m_stall_cnt = 0;
  int m_mis_cnt = 0;
  bit m_valid = 0;

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic bit m_hit(logic wreg, logic [4:0] rn, logic isreg, logic [4:0] r);
    return wreg && (rn != 0) && isreg && (rn == r);
  endfunction

  function automatic logic [1:0] m_fwd(logic isreg, logic [4:0] r);
    if (m_hit(exe_wreg, exe_rn, isreg, r) && !exe_m2reg) return 2'b01;
    if (m_hit(mem_wreg, mem_rn, isreg, r)) return mem_m2reg ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    bit raw;
    raw = id_valid && exe_wreg && exe_m2reg &&
          (m_hit(exe_wreg, exe_rn, id_rs1_isreg, rs) || m_hit(exe_wreg, exe_rn, id_rs2_isreg, rt));
    return raw && !m_stalled_last;
  endfunction

  function automatic bit m_flush();
    return id_valid && id_is_branch && !m_stall() && (id_taken != id_pred);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (clrn) begin
      for (int i = 0; i < NENT; i++) m_bht[i] = 1;
      m_stalled_last = 0;
      m_stall_cnt = 0;
      m_mis_cnt = 0;
      m_valid = 1;
    end else if (m_valid) begin
      bit s, f;
      int k;
      s = m_stall();
      f = m_flush();
      if (s && m_stall_cnt < CMAX) m_stall_cnt++;
      if (f && m_mis_cnt < CMAX) m_mis_cnt++;
      if (id_valid && id_is_branch && !s) begin
        k = m_idx(id_pc);
        if (id_taken) m_bht[k] = (m_bht[k] < 3) ? m_bht[k] + 1 : 3;
        else          m_bht[k] = (m_bht[k] > 0) ? m_bht[k] - 1 : 0;
      end
      m_stalled_last = s;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_pred_taken", 32'(pred_taken), 32'(m_bht[m_idx(if_pc)] >= 2));
      check("m_stall", 32'(stall), 32'(m_stall()));
      check("m_flush", 32'(flush), 32'(m_flush()));
      check("m_fwda", 32'(fwda), 32'(m_fwd(id_rs1_isreg, rs)));
      check("m_fwdb", 32'(fwdb), 32'(m_fwd(id_rs2_isreg, rt)));
      check("m_stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
      check("m_mispred_cnt", 32'(mispred_cnt), 32'(m_mis_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_pc = '0; id_valid = 0; id_is_branch = 0; id_pc = '0; id_pred = 0; id_taken = 0;
    rs = '0; rt = '0; id_rs1_isreg = 0; id_rs2_isreg = 0;
    exe_wreg = 0; exe_m2reg = 0; exe_rn = '0; mem_wreg = 0; mem_m2reg = 0; mem_rn = '0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    exe_wreg = 1; exe_m2reg = 1; exe_rn = r; id_valid = 1; rs = r; id_rs1_isreg = 1;
  endtask

  initial begin
    // Initial reset, then the cycle after reset with all inputs 0.
    clrn = 1;
    tick();
    clrn = 0;
    @(negedge clk);
    check("rst_pred", 32'(pred_taken), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_fwd", 32'({fwda, fwdb}), 32'd0);
    check("rst_cnts", 32'({stall_cnt, mispred_cnt}), 32'd0);

    // Random history, then reset and sweep every table slot.
    for (int c = 0; c < 60; c++) begin
      tick();
      if_pc = $urandom; id_pc = $urandom;
      id_valid = 1'($urandom); id_is_branch = 1'($urandom);
      id_pred = 1'($urandom); id_taken = 1'($urandom);
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
      id_rs1_isreg = 1'($urandom); id_rs2_isreg = 1'($urandom);
      exe_wreg = 1'($urandom); exe_m2reg = 1'($urandom); exe_rn = 5'($urandom_range(0, 3));
      mem_wreg = 1'($urandom); mem_m2reg = 1'($urandom); mem_rn = 5'($urandom_range(0, 3));
    end
    tick();
    clear_inputs();
    clrn = 1;
    tick();
    clrn = 0;
    for (int i = 0; i < NENT; i++) begin
      if_pc = {$urandom, 2'b00} & 32'hFFFF_FF03 | 32'(i << 2);
      @(negedge clk);
      check("sweep_pred", 32'(pred_taken), 32'd0);
      tick();
    end
    @(negedge clk);
    check("sweep_cnts", 32'({stall_cnt, mispred_cnt}), 32'd0);

    // Load-use held three cycles: 1,0,1.
    tick();
    set_load_use(5'd5);
    @(negedge clk); check("lu_c0", 32'(stall), 32'd1);
    tick();         @(negedge clk); check("lu_c1", 32'(stall), 32'd0);
    tick();         @(negedge clk); check("lu_c2", 32'(stall), 32'd1);
    tick();
    clear_inputs();
    @(negedge clk); check("lu_cnt", 32'(stall_cnt), 32'd2);

    // Forwarding priorities on operand B.
    tick();
    id_valid = 1; rt = 7; id_rs2_isreg = 1;
    exe_wreg = 1; exe_rn = 7; mem_wreg = 1; mem_rn = 7;
    @(negedge clk); check("fwd_exe", 32'(fwdb), 32'b01);
    tick(); exe_wreg = 0;
    @(negedge clk); check("fwd_mem", 32'(fwdb), 32'b10);
    tick(); mem_m2reg = 1;
    @(negedge clk); check("fwd_load", 32'(fwdb), 32'b11);
    tick(); rt = 0;
    @(negedge clk); check("fwd_r0", 32'(fwdb), 32'b00);
    tick();
    clear_inputs();

    // Branch at 0x40 taken three times, prediction tracking the counter.
    id_valid = 1; id_is_branch = 1; id_pc = 32'h40; id_taken = 1; id_pred = 0;
    @(negedge clk); check("br_f1", 32'(flush), 32'd1);
    tick(); id_pred = 1;
    @(negedge clk); check("br_f2", 32'(flush), 32'd0);
    tick();
    @(negedge clk); check("br_f3", 32'(flush), 32'd0);
    tick();
    clear_inputs();
    if_pc = 32'h40;
    @(negedge clk);
    check("br_pred", 32'(pred_taken), 32'd1);
    check("br_mis", 32'(mispred_cnt), 32'd1);

    // Same-index lookup and update: read-before-write.
    tick();
    if_pc = 32'h80; id_pc = 32'h80; id_valid = 1; id_is_branch = 1; id_taken = 1; id_pred = 0;
    @(negedge clk); check("rbw_now", 32'(pred_taken), 32'd0);
    tick(); id_valid = 0;
    @(negedge clk); check("rbw_next", 32'(pred_taken), 32'd1);

    // Branch blocked by a load-use stall resolves in the bubble cycle.
    tick();
    clear_inputs();
    set_load_use(5'd3);
    id_is_branch = 1; id_pc = 32'hC0; if_pc = 32'hC0; id_taken = 1; id_pred = 0;
    @(negedge clk);
    check("hz_stall", 32'(stall), 32'd1);
    check("hz_flush0", 32'(flush), 32'd0);
    tick();
    @(negedge clk);
    check("hz_flush1", 32'(flush), 32'd1);
    check("hz_pred_b", 32'(pred_taken), 32'd0);
    tick();
    clear_inputs();
    if_pc = 32'hC0;
    @(negedge clk);
    check("hz_pred_a", 32'(pred_taken), 32'd1);
    check("hz_mis", 32'(mispred_cnt), 32'd3);

    // Saturation of both counters.
    tick();
    set_load_use(5'd9);
    repeat (40) tick();
    clear_inputs();
    @(negedge clk); check("sat_stall", 32'(stall_cnt), 32'(CMAX));
    tick();
    id_valid = 1; id_is_branch = 1; id_pred = 1; id_taken = 0; id_pc = 32'h10;
    repeat (20) tick();
    clear_inputs();
    @(negedge clk); check("sat_mis", 32'(mispred_cnt), 32'(CMAX));

    // Reset while in BUBBLE, and a stall shown during a reset cycle.
    tick();
    set_load_use(5'd4);
    @(negedge clk); check("mr_c1", 32'(stall), 32'd1);
    tick(); clrn = 1;
    @(negedge clk); check("mr_c2", 32'(stall), 32'd0);
    tick();
    @(negedge clk); check("mr_c3", 32'(stall), 32'd1);
    tick(); clrn = 0;
    @(negedge clk);
    check("mr_c4", 32'(stall), 32'd1);
    check("mr_cnt4", 32'(stall_cnt), 32'd0);
    tick();
    @(negedge clk);
    check("mr_c5", 32'(stall), 32'd0);
    check("mr_cnt5", 32'(stall_cnt), 32'd1);
    tick();
    clear_inputs();
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
